// File: rtl/alu_issue_pkg.sv
// Shared MIPS ISA constants (opcodes, ALU function codes) and the issue-stage
// output bundle used by the decoder and the ID/EX register.
package alu_issue_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALU function codes reuse the R-type funct encoding; FUN_NO is an unused slot.
    localparam logic [5:0] FUN_SLL  = 6'h00;
    localparam logic [5:0] FUN_SRL  = 6'h02;
    localparam logic [5:0] FUN_SRA  = 6'h03;
    localparam logic [5:0] FUN_SLLV = 6'h04;
    localparam logic [5:0] FUN_SRLV = 6'h06;
    localparam logic [5:0] FUN_SRAV = 6'h07;
    localparam logic [5:0] FUN_JR   = 6'h08;
    localparam logic [5:0] FUN_ADD  = 6'h20;
    localparam logic [5:0] FUN_ADDU = 6'h21;
    localparam logic [5:0] FUN_SUB  = 6'h22;
    localparam logic [5:0] FUN_SUBU = 6'h23;
    localparam logic [5:0] FUN_AND  = 6'h24;
    localparam logic [5:0] FUN_OR   = 6'h25;
    localparam logic [5:0] FUN_XOR  = 6'h26;
    localparam logic [5:0] FUN_NOR  = 6'h27;
    localparam logic [5:0] FUN_SLT  = 6'h2A;
    localparam logic [5:0] FUN_SLTU = 6'h2B;
    localparam logic [5:0] FUN_NO   = 6'h3F;

    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [5:0]  alu_funct;
        logic [4:0]  write_reg;
        logic        reg_write;
        logic        is_branch;
        logic        branch_ne;
        logic        illegal;
    } issue_t;

    localparam issue_t ISSUE_RESET = '{
        op_a:      32'd0,
        op_b:      32'd0,
        alu_funct: FUN_NO,
        write_reg: 5'd0,
        reg_write: 1'b0,
        is_branch: 1'b0,
        branch_ne: 1'b0,
        illegal:   1'b0
    };

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'd0, imm};
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational instruction decoder: maps an instruction word and its register
// operands onto the ALU operand/function bundle plus write-back control.
module issue_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    output issue_t      o_dec
);

    logic [5:0]  w_op;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic        w_unused_rs;
    issue_t      w_dec;

    assign w_op    = i_instr[31:26];
    assign w_rt    = i_instr[20:16];
    assign w_rd    = i_instr[15:11];
    assign w_shamt = i_instr[10:6];
    assign w_funct = i_instr[5:0];
    assign w_imm   = i_instr[15:0];

    // The rs index is resolved upstream; only its register value arrives here.
    assign w_unused_rs = ^i_instr[25:21];

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves it unassigned (no latch).
        w_dec           = ISSUE_RESET;
        w_dec.op_a      = i_rs_data;
        w_dec.op_b      = i_rt_data;
        w_dec.write_reg = w_rt;
        w_dec.reg_write = 1'b1;

        case (w_op)
            OP_RTYPE: begin
                w_dec.alu_funct = w_funct;
                w_dec.write_reg = w_rd;
                case (w_funct)
                    FUN_SLL, FUN_SRL, FUN_SRA: begin
                        w_dec.op_a = {27'd0, w_shamt};
                    end
                    FUN_JR: begin
                        w_dec.reg_write = 1'b0;
                    end
                    FUN_SLLV, FUN_SRLV, FUN_SRAV, FUN_ADD, FUN_ADDU, FUN_SUB,
                    FUN_SUBU, FUN_AND, FUN_OR, FUN_XOR, FUN_NOR, FUN_SLT,
                    FUN_SLTU: begin
                        w_dec.op_a = i_rs_data;
                    end
                    default: begin
                        w_dec.alu_funct = FUN_NO;
                        w_dec.illegal   = 1'b1;
                        w_dec.reg_write = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                w_dec.alu_funct = FUN_ADD;
                w_dec.op_b      = sext16(w_imm);
            end
            OP_ADDIU: begin
                w_dec.alu_funct = FUN_ADDU;
                w_dec.op_b      = sext16(w_imm);
            end
            OP_SLTI: begin
                w_dec.alu_funct = FUN_SLT;
                w_dec.op_b      = sext16(w_imm);
            end
            // sltiu still sign-extends; the comparison itself is unsigned.
            OP_SLTIU: begin
                w_dec.alu_funct = FUN_SLTU;
                w_dec.op_b      = sext16(w_imm);
            end
            OP_ANDI: begin
                w_dec.alu_funct = FUN_AND;
                w_dec.op_b      = zext16(w_imm);
            end
            OP_ORI: begin
                w_dec.alu_funct = FUN_OR;
                w_dec.op_b      = zext16(w_imm);
            end
            OP_XORI: begin
                w_dec.alu_funct = FUN_XOR;
                w_dec.op_b      = zext16(w_imm);
            end
            // lui is executed as (imm << 16) on the shifter.
            OP_LUI: begin
                w_dec.alu_funct = FUN_SLL;
                w_dec.op_a      = 32'd16;
                w_dec.op_b      = zext16(w_imm);
            end
            OP_LW: begin
                w_dec.alu_funct = FUN_ADDU;
                w_dec.op_b      = sext16(w_imm);
            end
            OP_SW: begin
                w_dec.alu_funct = FUN_ADDU;
                w_dec.op_b      = sext16(w_imm);
                w_dec.reg_write = 1'b0;
            end
            OP_BEQ, OP_BNE: begin
                w_dec.alu_funct = FUN_SUBU;
                w_dec.is_branch = 1'b1;
                w_dec.branch_ne = (w_op == OP_BNE);
                w_dec.reg_write = 1'b0;
            end
            default: begin
                w_dec.alu_funct = FUN_NO;
                w_dec.illegal   = 1'b1;
                w_dec.reg_write = 1'b0;
            end
        endcase

        // $0 is hard-wired; never claim a write to it.
        if (w_dec.write_reg == 5'd0) begin
            w_dec.reg_write = 1'b0;
        end
    end

    assign o_dec = w_dec;

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue register: single valid/ready stage holding the decoded ALU
// operands and write-back control, with stall, flush and synchronous reset.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        resetN,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] instr,
    input  logic [31:0] rsData,
    input  logic [31:0] rtData,
    input  logic        flush,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] opA,
    output logic [31:0] opB,
    output logic [5:0]  aluFunct,
    output logic [4:0]  writeReg,
    output logic        regWrite,
    output logic        isBranch,
    output logic        branchNe,
    output logic        illegal
);

    state_t r_state;
    state_t w_state_next;
    issue_t r_out;
    issue_t w_dec;
    logic   w_accept;
    logic   w_consume;

    issue_decode u_decode (
        .i_instr   (instr),
        .i_rs_data (rsData),
        .i_rt_data (rtData),
        .o_dec     (w_dec)
    );

    assign outValid  = (r_state == ST_FULL);
    assign inReady   = !outValid || outReady;
    assign w_accept  = inValid && inReady;
    assign w_consume = outValid && outReady;

    // Flush beats accept, accept beats consume: a same-cycle consume+accept stays FULL.
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else if (w_accept) begin
            w_state_next = ST_FULL;
        end else if (w_consume) begin
            w_state_next = ST_EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Data fields only move on a load; flush just kills the side-effecting controls.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_out <= ISSUE_RESET;
        end else if (flush) begin
            r_out.reg_write <= 1'b0;
            r_out.is_branch <= 1'b0;
        end else if (w_accept) begin
            r_out <= w_dec;
        end
    end

    assign opA      = r_out.op_a;
    assign opB      = r_out.op_b;
    assign aluFunct = r_out.alu_funct;
    assign writeReg = r_out.write_reg;
    assign regWrite = r_out.reg_write;
    assign isBranch = r_out.is_branch;
    assign branchNe = r_out.branch_ne;
    assign illegal  = r_out.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed ISA scenarios plus a randomized
// run scored against a behavioural decode/handshake model.
module tb_alu_issue;

    import alu_issue_pkg::FUN_NO;

    logic        clk = 1'b0;
    logic        resetN;
    logic        inValid;
    logic        inReady;
    logic [31:0] instr;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic        flush;
    logic        outValid;
    logic        outReady;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [5:0]  aluFunct;
    logic [4:0]  writeReg;
    logic        regWrite;
    logic        isBranch;
    logic        branchNe;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  f;
        logic [4:0]  wr;
        logic        rw;
        logic        br;
        logic        ne;
        logic        ill;
    } exp_t;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk      (clk),
        .resetN   (resetN),
        .inValid  (inValid),
        .inReady  (inReady),
        .instr    (instr),
        .rsData   (rsData),
        .rtData   (rtData),
        .flush    (flush),
        .outValid (outValid),
        .outReady (outReady),
        .opA      (opA),
        .opB      (opB),
        .aluFunct (aluFunct),
        .writeReg (writeReg),
        .regWrite (regWrite),
        .isBranch (isBranch),
        .branchNe (branchNe),
        .illegal  (illegal)
    );

    // Reference decode from the MIPS mnemonic table, with numeric ISA encodings.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t        e;
        int unsigned op;
        int unsigned fn;
        logic [31:0] sx;
        logic [31:0] zx;
        op = ins[31:26];
        fn = ins[5:0];
        sx = 32'($signed(ins[15:0]));
        zx = 32'(ins[15:0]);
        e     = '0;
        e.a   = rs;
        e.b   = rt;
        e.wr  = ins[20:16];
        e.rw  = 1'b1;
        if (op == 0) begin
            e.wr = ins[15:11];
            e.f  = 6'(fn);
            if (fn == 0 || fn == 2 || fn == 3) e.a = 32'(ins[10:6]);
            if (fn == 8) e.rw = 1'b0;
            if (!(fn inside {0, 2, 3, 4, 6, 7, 8, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43})) begin
                e.f = FUN_NO; e.ill = 1'b1; e.rw = 1'b0;
            end
        end else if (op == 8)  begin e.f = 6'h20; e.b = sx; end
        else if (op == 9)  begin e.f = 6'h21; e.b = sx; end
        else if (op == 10) begin e.f = 6'h2A; e.b = sx; end
        else if (op == 11) begin e.f = 6'h2B; e.b = sx; end
        else if (op == 12) begin e.f = 6'h24; e.b = zx; end
        else if (op == 13) begin e.f = 6'h25; e.b = zx; end
        else if (op == 14) begin e.f = 6'h26; e.b = zx; end
        else if (op == 15) begin e.f = 6'h00; e.a = 16; e.b = zx; end
        else if (op == 35) begin e.f = 6'h21; e.b = sx; end
        else if (op == 43) begin e.f = 6'h21; e.b = sx; e.rw = 1'b0; end
        else if (op == 4 || op == 5) begin
            e.f = 6'h23; e.br = 1'b1; e.ne = (op == 5); e.rw = 1'b0;
        end else begin
            e.f = FUN_NO; e.ill = 1'b1; e.rw = 1'b0;
        end
        if (e.wr == 0) e.rw = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [16] = '{6'd0, 6'd0, 6'd0, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12,
                                 6'd13, 6'd14, 6'd15, 6'd35, 6'd43, 6'd4, 6'd5, 6'd0};
        logic [5:0] fns [12] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd7, 6'd8, 6'd32, 6'd33,
                                 6'd35, 6'd39, 6'd42, 6'd43};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[31:26] = ops[$urandom_range(0, 15)];
        if (w[31:26] == 6'd0 && $urandom_range(0, 5) != 0) w[5:0] = fns[$urandom_range(0, 11)];
        return w;
    endfunction

    task automatic idle_inputs();
        inValid  = 1'b0;
        flush    = 1'b0;
        outReady = 1'b1;
        instr    = 32'd0;
        rsData   = 32'd0;
        rtData   = 32'd0;
    endtask

    // Offer one instruction with outReady high; returns #1 after the loading edge.
    task automatic issue_one(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        instr    = ins;
        rsData   = rs;
        rtData   = rt;
        inValid  = 1'b1;
        outReady = 1'b1;
        @(posedge clk); #1;
        inValid  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (outValid !== 1'b0) begin n_err++; $display("FAIL reset_outValid: got %b want 0", outValid); end
        n_vec++; if (opA !== 32'd0 || opB !== 32'd0) begin n_err++; $display("FAIL reset_ops: got %h/%h want 0/0", opA, opB); end
        n_vec++; if (aluFunct !== FUN_NO) begin n_err++; $display("FAIL reset_funct: got %h want %h", aluFunct, FUN_NO); end
        n_vec++; if ({writeReg, regWrite, isBranch, branchNe, illegal} !== 9'd0) begin
            n_err++; $display("FAIL reset_ctrl: got %h want 0", {writeReg, regWrite, isBranch, branchNe, illegal});
        end
        n_vec++; if (inReady !== 1'b1) begin n_err++; $display("FAIL reset_inReady: got %b want 1", inReady); end
        resetN = 1'b1;
    endtask

    task automatic test_decode_directed();
        // addi $8,$16,-1
        issue_one({6'h08, 5'd16, 5'd8, 16'hFFFF}, 32'd5, 32'd99);
        n_vec++; if (outValid !== 1'b1 || aluFunct !== 6'h20 || opA !== 32'd5 || opB !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL addi_ops: got v=%b f=%h a=%h b=%h want v=1 f=20 a=5 b=ffffffff", outValid, aluFunct, opA, opB);
        end
        n_vec++; if (writeReg !== 5'd8 || regWrite !== 1'b1) begin
            n_err++; $display("FAIL addi_wb: got wr=%0d rw=%b want wr=8 rw=1", writeReg, regWrite);
        end
        // lui $9,0x1234
        issue_one({6'h0F, 5'd0, 5'd9, 16'h1234}, 32'hDEAD_BEEF, 32'd0);
        n_vec++; if (aluFunct !== 6'h00 || opA !== 32'd16 || opB !== 32'h0000_1234 || writeReg !== 5'd9) begin
            n_err++; $display("FAIL lui: got f=%h a=%h b=%h wr=%0d want f=00 a=10 b=00001234 wr=9", aluFunct, opA, opB, writeReg);
        end
        // sll $3,$4,7
        issue_one({6'h00, 5'd0, 5'd4, 5'd3, 5'd7, 6'h00}, 32'h5555_5555, 32'd1);
        n_vec++; if (aluFunct !== 6'h00 || opA !== 32'd7 || opB !== 32'd1 || writeReg !== 5'd3 || regWrite !== 1'b1) begin
            n_err++; $display("FAIL sll: got f=%h a=%h b=%h wr=%0d rw=%b want f=00 a=7 b=1 wr=3 rw=1", aluFunct, opA, opB, writeReg, regWrite);
        end
        // addi $0,$5,3
        issue_one({6'h08, 5'd5, 5'd0, 16'd3}, 32'd1, 32'd2);
        n_vec++; if (regWrite !== 1'b0 || writeReg !== 5'd0) begin
            n_err++; $display("FAIL addi_r0: got rw=%b wr=%0d want rw=0 wr=0", regWrite, writeReg);
        end
        // bne $7,$7,+4
        issue_one({6'h05, 5'd7, 5'd7, 16'd4}, 32'd7, 32'd7);
        n_vec++; if (aluFunct !== 6'h23 || isBranch !== 1'b1 || branchNe !== 1'b1 || regWrite !== 1'b0 || opB !== 32'd7) begin
            n_err++; $display("FAIL bne: got f=%h br=%b ne=%b rw=%b b=%h want f=23 br=1 ne=1 rw=0 b=7", aluFunct, isBranch, branchNe, regWrite, opB);
        end
        // op 111111
        issue_one({6'h3F, 26'h123_4567}, 32'd1, 32'd2);
        n_vec++; if (illegal !== 1'b1 || aluFunct !== FUN_NO || regWrite !== 1'b0 || isBranch !== 1'b0) begin
            n_err++; $display("FAIL illegal_op: got ill=%b f=%h rw=%b br=%b want ill=1 f=%h rw=0 br=0", illegal, aluFunct, regWrite, isBranch, FUN_NO);
        end
        // R-type with unknown funct 0x3E
        issue_one({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3E}, 32'd1, 32'd2);
        n_vec++; if (illegal !== 1'b1 || aluFunct !== FUN_NO || regWrite !== 1'b0) begin
            n_err++; $display("FAIL illegal_funct: got ill=%b f=%h rw=%b want ill=1 f=%h rw=0", illegal, aluFunct, regWrite, FUN_NO);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_pressure();
        issue_one({6'h09, 5'd1, 5'd10, 16'h0042}, 32'h0000_1000, 32'd0);
        outReady = 1'b0;
        inValid  = 1'b1;
        instr    = {6'h0D, 5'd2, 5'd11, 16'h8001};
        rsData   = 32'hAAAA_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (inReady !== 1'b0) begin n_err++; $display("FAIL stall_inReady[%0d]: got %b want 0", i, inReady); end
            @(posedge clk); #1;
            n_vec++; if (outValid !== 1'b1 || aluFunct !== 6'h21 || opA !== 32'h0000_1000 || opB !== 32'h0000_0042 || writeReg !== 5'd10) begin
                n_err++; $display("FAIL stall_hold[%0d]: got v=%b f=%h a=%h b=%h wr=%0d want v=1 f=21 a=1000 b=42 wr=10",
                                  i, outValid, aluFunct, opA, opB, writeReg);
            end
        end
        outReady = 1'b1;
        #1;
        n_vec++; if (inReady !== 1'b1) begin n_err++; $display("FAIL release_inReady: got %b want 1", inReady); end
        @(posedge clk); #1;
        inValid = 1'b0;
        n_vec++; if (outValid !== 1'b1 || aluFunct !== 6'h25 || opA !== 32'hAAAA_0000 || opB !== 32'h0000_8001 || writeReg !== 5'd11) begin
            n_err++; $display("FAIL no_bubble: got v=%b f=%h a=%h b=%h wr=%0d want v=1 f=25 a=aaaa0000 b=8001 wr=11",
                              outValid, aluFunct, opA, opB, writeReg);
        end
        @(posedge clk); #1;
        n_vec++; if (outValid !== 1'b0) begin n_err++; $display("FAIL drain: got %b want 0", outValid); end
    endtask

    task automatic test_flush();
        issue_one({6'h04, 5'd3, 5'd3, 16'd8}, 32'd1, 32'd1);
        inValid = 1'b1;
        flush   = 1'b1;
        instr   = {6'h08, 5'd1, 5'd12, 16'd77};
        rsData  = 32'd100;
        @(posedge clk); #1;
        inValid = 1'b0;
        flush   = 1'b0;
        n_vec++; if (outValid !== 1'b0 || regWrite !== 1'b0 || isBranch !== 1'b0) begin
            n_err++; $display("FAIL flush_accept: got v=%b rw=%b br=%b want 0/0/0", outValid, regWrite, isBranch);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_vec++; if (outValid !== 1'b0) begin n_err++; $display("FAIL flush_dropped[%0d]: got v=%b want 0", i, outValid); end
        end
    endtask

    task automatic test_reset_mid_stall();
        issue_one({6'h05, 5'd4, 5'd5, 16'd2}, 32'd9, 32'd8);
        outReady = 1'b0;
        inValid  = 1'b1;
        flush    = 1'b1;
        resetN   = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (outValid !== 1'b0 || opA !== 32'd0 || opB !== 32'd0 || aluFunct !== FUN_NO ||
                     {writeReg, regWrite, isBranch, branchNe, illegal} !== 9'd0) begin
            n_err++; $display("FAIL reset_stall: got v=%b a=%h b=%h f=%h ctl=%h want all reset values",
                              outValid, opA, opB, aluFunct, {writeReg, regWrite, isBranch, branchNe, illegal});
        end
        resetN = 1'b1;
        idle_inputs();
    endtask

    task automatic test_random();
        logic m_valid;
        exp_t m_out;
        logic acc;
        m_valid = 1'b0;
        m_out   = '0;
        m_out.f = FUN_NO;
        idle_inputs();
        resetN = 1'b0;
        @(posedge clk); #1;
        resetN = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            instr    = rand_instr();
            rsData   = $urandom;
            rtData   = $urandom;
            inValid  = ($urandom_range(0, 3) != 0);
            outReady = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            resetN   = ($urandom_range(0, 99) != 0);
            #1;
            n_vec++; if (inReady !== (!m_valid || outReady)) begin
                n_err++; $display("FAIL rnd_inReady[%0d]: got %b want %b", c, inReady, !m_valid || outReady);
            end
            acc = inValid && (!m_valid || outReady);
            if (!resetN) begin
                m_valid = 1'b0; m_out = '0; m_out.f = FUN_NO;
            end else if (flush) begin
                m_valid = 1'b0; m_out.rw = 1'b0; m_out.br = 1'b0;
            end else if (acc) begin
                m_valid = 1'b1; m_out = ref_decode(instr, rsData, rtData);
            end else if (m_valid && outReady) begin
                m_valid = 1'b0;
            end
            @(posedge clk); #1;
            n_vec++; if (outValid !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, outValid, m_valid); end
            n_vec++; if ({aluFunct, regWrite, isBranch, illegal} !== {m_out.f, m_out.rw, m_out.br, m_out.ill}) begin
                n_err++; $display("FAIL rnd_ctrl[%0d]: got f=%h rw=%b br=%b ill=%b want f=%h rw=%b br=%b ill=%b",
                                  c, aluFunct, regWrite, isBranch, illegal, m_out.f, m_out.rw, m_out.br, m_out.ill);
            end
            if (!m_out.ill) begin
                n_vec++; if (opA !== m_out.a || opB !== m_out.b || writeReg !== m_out.wr) begin
                    n_err++; $display("FAIL rnd_data[%0d]: got a=%h b=%h wr=%0d want a=%h b=%h wr=%0d",
                                      c, opA, opB, writeReg, m_out.a, m_out.b, m_out.wr);
                end
            end
            if (m_out.br) begin
                n_vec++; if (branchNe !== m_out.ne) begin n_err++; $display("FAIL rnd_bne[%0d]: got %b want %b", c, branchNe, m_out.ne); end
            end
        end
        resetN = 1'b1;
        idle_inputs();
    endtask

    initial begin
        resetN = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        test_reset();
        test_decode_directed();
        test_back_pressure();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-stage issue register feeding the ALU in the MIPS datapath. It accepts a fetched instruction word plus its register-file operands and decodes the instruction into the ALU function code, `opA`/`opB` and write-back control. It holds the result in a single valid/ready pipeline register (the ID/EX boundary), with stall and flush support. The registered outputs connect directly to the ALU's `opA`, `opB` and `aluFunct` inputs.

## Interface
- No parameters; all widths are fixed by the ISA (32-bit data, 6-bit funct, 5-bit register index).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetN`  in  1  synchronous, active-low reset.
- `inValid`  in  1  `instr`, `rsData` and `rtData` are valid this cycle.
- `inReady`  out  1  the stage can accept an input this cycle.
- `instr`  in  32  raw instruction word.
- `rsData`  in  32  register-file value of `rs`.
- `rtData`  in  32  register-file value of `rt`.
- `flush`  in  1  discard the held entry and any input offered this cycle.
- `outValid`  out  1  the registered outputs hold a live instruction.
- `outReady`  in  1  the downstream EX/MEM stage consumes the entry this cycle.
- `opA`  out  32  ALU operand A.
- `opB`  out  32  ALU operand B.
- `aluFunct`  out  6  ALU function code (`FUN_*` encoding).
- `writeReg`  out  5  destination register index.
- `regWrite`  out  1  the instruction writes `writeReg`.
- `isBranch`  out  1  beq/bne; EX evaluates the ALU `zero` output.
- `branchNe`  out  1  1 = bne, 0 = beq (meaningful only when `isBranch`).
- `illegal`  out  1  unrecognised opcode or funct.

## Operation
- **Field extraction:** op=`instr[31:26]`, rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0]. `sext` = sign-extended imm, `zext` = zero-extended imm.
- **R-type (op 000000):**
  - `aluFunct` = funct; `writeReg` = rd; `regWrite` = 1.
  - SLL/SRL/SRA: `opA` = {27'b0, shamt}, `opB` = rtData.
  - All other R-type functs: `opA` = rsData, `opB` = rtData.
  - JR: `regWrite` = 0.
  - Unknown funct: `aluFunct` = `FUN_NO`, `illegal` = 1, `regWrite` = 0.
- **I-type, common rules:** `opA` = rsData, `writeReg` = rt, `regWrite` = 1, unless stated otherwise below.
- **I-type arithmetic and compare:**
  - addi → ADD, addiu → ADDU, slti → SLT, sltiu → SLTU; all use `opB` = sext.
  - sltiu compares unsigned against the sign-extended immediate.
- **I-type logical:** andi → AND, ori → OR, xori → XOR; all use `opB` = zext.
- **lui:** `aluFunct` = SLL, `opA` = 32'd16, `opB` = zext.
- **lw/sw:** `aluFunct` = ADDU, `opB` = sext. sw has `regWrite` = 0.
- **beq/bne:** `aluFunct` = SUBU, `opB` = rtData, `isBranch` = 1, `regWrite` = 0.
- **Any other opcode:** `aluFunct` = `FUN_NO`, `illegal` = 1, `regWrite` = 0, `isBranch` = 0.
- **`writeReg` = 0 forces `regWrite` = 0.**
- **Handshake:**
  - `inReady` = !`outValid` || `outReady` (combinational, no skid buffer).
  - Accept = `inValid` && `inReady`; accepted decode results load the register.
  - Consume = `outValid` && `outReady`.
- **State update each edge** (two states, EMPTY/FULL = `outValid`), checked in this order:
  1. flush → EMPTY.
  2. accept → FULL.
  3. consume → EMPTY.
  4. otherwise hold.
- **Output stability:** while `outValid` && !`outReady`, every output holds stable.

## Timing
- Latency is 1 cycle from accept to `outValid`.
- Throughput is one instruction per cycle when `outReady` is held high.
- Simultaneous consume and accept replaces the entry with no bubble.
- Flush wins over a simultaneous accept: the input is dropped, `outValid` = 0 on the next cycle, and the upstream must treat the dropped instruction as squashed.
- Reset (`resetN` low at an edge) overrides flush, accept and everything else, including mid-stall. Reset values:
  - `outValid` = 0.
  - `opA`, `opB` = 0.
  - `aluFunct` = `FUN_NO`.
  - `writeReg` = 0.
  - `regWrite`, `isBranch`, `branchNe`, `illegal` = 0.
- Flush clears `regWrite` and `isBranch` as well as `outValid`.
- While EMPTY and not loading, the data fields hold their previous values.
- `inReady` is low only when FULL and `outReady` is low.

## Structure
- `FUN_*` codes and the new `OP_*` opcode constants live in the shared ISA header; no literal opcodes appear in the block.
- One natural sub-module: `issue_decode`, purely combinational, mapping (`instr`, `rsData`, `rtData`) to the output bundle plus `illegal`.
- `alu_issue` contains only the handshake state and the output register.

## Test plan
- **addi with negative immediate:** addi $8,$16,-1 with rsData = 5 → next cycle: `aluFunct` = ADD, `opA` = 5, `opB` = FFFFFFFF, `writeReg` = 8, `regWrite` = 1.
- **lui:** lui $9,0x1234 → `aluFunct` = SLL, `opA` = 16, `opB` = 00001234, `writeReg` = 9.
- **Constant shift:** sll $3,$4,7 with rtData = 1 → `opA` = 7, `opB` = 1, `aluFunct` = SLL. Also drive addi $0,… → `regWrite` = 0.
- **Back-pressure:** `outReady` = 0 for 3 cycles while FULL → `inReady` = 0 and outputs frozen. `outReady` = 1 with `inValid` = 1 → next entry appears the following cycle with no bubble.
- **Flush vs. accept:** flush asserted together with an accept → `outValid` = 0 next cycle, and the dropped entry never appears.
- **Reset, branch and illegal:**
  - `resetN` low while FULL and stalled → all outputs at reset values next cycle.
  - bne with rs = rt = 7 → `aluFunct` = SUBU, `isBranch` = 1, `branchNe` = 1.
  - op 111111 → `illegal` = 1, `aluFunct` = `FUN_NO`.
